// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered channel-select decoder.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Operating state is chosen fresh every cycle from the enable and mode pins.
  function automatic state_t decode_state(input logic en, input logic mode);
    state_t st;
    st = ST_IDLE;
    if (en) begin
      st = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
    end
    return st;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Generalised enable decoder: one-hot of the index when enabled, all-zero otherwise.
module onehot_dec #(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]      in,
  input  logic                  en,
  output logic [(2**SEL_W)-1:0] out
);

  localparam int unsigned OUT_W = 2 ** SEL_W;

  always_comb begin
    out = '0;
    if (en) begin
      out = OUT_W'(1) << in;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot channel select, driven either directly from sel or by a
// dwell-timed scan counter that walks every channel in turn.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] out_1,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int unsigned     OUT_W   = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] IDX_MAX = '1;

  state_t               state_q, next_state;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 wrap_d;
  logic                 dec_en;
  logic [OUT_W-1:0]     out_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_1   <= '0;
      wrap    <= 1'b0;
    end else begin
      state_q <= next_state;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_1   <= out_d;
      wrap    <= wrap_d;
    end
  end

  // Next index, dwell count and wrap flag for the state being entered this cycle.
  always_comb begin
    next_state = decode_state(en, mode);
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    case (next_state)
      ST_DIRECT: begin
        idx_d = sel;
        // The counter stays zero while in DIRECT, so it only needs clearing on entry.
        cnt_d = (state_q == ST_DIRECT) ? cnt_q : '0;
      end
      ST_SCAN: begin
        // >= so a dwell lowered below the running count advances instead of stalling.
        if (cnt_q >= dwell) begin
          cnt_d  = '0;
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = (idx_q == IDX_MAX);
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  assign dec_en = (next_state != ST_IDLE);

  onehot_dec #(
    .SEL_W(SEL_W)
  ) u_onehot_dec (
    .in  (idx_d),
    .en  (dec_en),
    .out (out_d)
  );

  assign idx = idx_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan with hand-computed expectations.
module tb_decoder_scan;

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 8;

  logic               clk;
  logic               reset;
  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         out_1;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

  int tests_run;
  int tests_failed;

  decoder_scan #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .sel   (sel),
    .dwell (dwell),
    .out_1 (out_1),
    .idx   (idx),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_out;
    int         exp_i;

    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b1;
    en    = 1'b0;
    mode  = 1'b0;
    sel   = '0;
    dwell = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_out", 32'(out_1), 32'h0);
    check("reset_idx", 32'(idx), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);

    // Direct mode: sel 0..7
    en   = 1'b1;
    mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = SEL_W'(s);
      step();
      exp_out = 8'h01 << s;
      check($sformatf("direct_out_%0d", s), 32'(out_1), 32'(exp_out));
      check($sformatf("direct_idx_%0d", s), 32'(idx), 32'(s));
    end
    en = 1'b0;
    step();
    check("en_off_out", 32'(out_1), 32'h00);
    check("en_off_idx_hold", 32'(idx), 32'd7);

    // Park on channel 0 then scan with dwell = 2
    en  = 1'b1;
    sel = 3'd0;
    step();
    check("park0_out", 32'(out_1), 32'h01);
    mode  = 1'b1;
    dwell = 8'd2;
    for (int k = 0; k < 48; k++) begin
      step();
      exp_i   = ((k + 1) / 3) % 8;
      exp_out = 8'h01 << exp_i;
      check($sformatf("scan2_out_%0d", k), 32'(out_1), 32'(exp_out));
      check($sformatf("scan2_wrap_%0d", k), 32'(wrap), (k == 23 || k == 47) ? 32'd1 : 32'd0);
    end

    // dwell = 0: one channel per cycle, starting from idx 0 with cnt 0
    dwell = 8'd0;
    for (int j = 0; j < 8; j++) begin
      step();
      exp_out = 8'h01 << ((j + 1) % 8);
      check($sformatf("scan0_out_%0d", j), 32'(out_1), 32'(exp_out));
      check($sformatf("scan0_wrap_%0d", j), 32'(wrap), (j == 7) ? 32'd1 : 32'd0);
    end

    // dwell 5 until count reaches 4, then drop to 1: must advance next cycle
    dwell = 8'd5;
    repeat (4) step();
    check("dwell5_hold_out", 32'(out_1), 32'h01);
    dwell = 8'd1;
    step();
    check("dwell_lower_out", 32'(out_1), 32'h02);
    check("dwell_lower_idx", 32'(idx), 32'd1);

    // Reach idx=5 with dwell_cnt=1, then drop en for 4 cycles
    mode = 1'b0;
    sel  = 3'd5;
    step();
    mode  = 1'b1;
    dwell = 8'd3;
    step();
    check("pre_pause_out", 32'(out_1), 32'h20);
    en = 1'b0;
    for (int p = 0; p < 4; p++) begin
      step();
      check($sformatf("pause_out_%0d", p), 32'(out_1), 32'h00);
      check($sformatf("pause_idx_%0d", p), 32'(idx), 32'd5);
    end
    en = 1'b1;
    step();
    check("resume_out_a", 32'(out_1), 32'h20);
    step();
    check("resume_out_b", 32'(out_1), 32'h20);
    step();
    check("resume_advance", 32'(out_1), 32'h40);
    check("resume_idx", 32'(idx), 32'd6);

    // SCAN -> DIRECT with sel=2 while idx=6
    mode = 1'b0;
    sel  = 3'd2;
    step();
    check("mode_chg_out", 32'(out_1), 32'h04);
    check("mode_chg_idx", 32'(idx), 32'd2);

    // en=0 coincident with a due advance: idx must hold
    sel = 3'd3;
    step();
    en    = 1'b0;
    mode  = 1'b1;
    dwell = 8'd0;
    step();
    check("en_wins_out", 32'(out_1), 32'h00);
    check("en_wins_idx", 32'(idx), 32'd3);
    en = 1'b1;
    step();
    check("en_back_out", 32'(out_1), 32'h10);
    check("en_back_idx", 32'(idx), 32'd4);

    // Asynchronous reset mid-scan, sampled before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", 32'(out_1), 32'h00);
    check("async_rst_idx", 32'(idx), 32'h0);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    #1;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
